aes_shiftrows_sched: RTL
========================

Name: aes_shiftrows_sched

Overview:
Byte-serial ShiftRows scheduler for the AES datapath. It accepts a 16-byte state one byte per beat in column-major order and stores it in four internal 4-byte row lanes, one lane per state row. It rotates each lane by its ShiftRows offset, then drains the state byte-serially in column-major order with ShiftRows, or InvShiftRows, applied. It sits between byte-serial SubBytes and MixColumns stages and uses valid/ready on both sides.

Parameters:
INVERSE, 0, 0 = ShiftRows (row r rotated left by r); 1 = InvShiftRows (row r rotated left by (4-r)%4).

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_byte  input  8  state byte; beat k carries row k%4, column k/4
in_valid  input  1  in_byte valid
in_ready  output  1  block accepts in_byte this cycle
out_byte  output  8  output state byte, column-major
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts out_byte
out_last  output  1  marks the 16th output byte of a block
busy  output  1  high in ROTATE or DRAIN

Behaviour:
- Storage: four lanes L0..L3, each 4 bytes s[0..3]. Two lane operations:
  - shift: s[0]<=new, s[i]<=s[i-1].
  - rotate: s[0]<=s[3], s[i]<=s[i-1].
  - Lane tap = s[3].
- State machine: LOAD -> ROTATE -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, shift in_byte into lane (cnt%4); cnt increments (4-bit).
  - On the 16th accept (cnt==15): go to ROTATE, cnt<=0. Lane r then holds col0 at s[3] through col3 at s[0].
- ROTATE: exactly 3 cycles, t=0,1,2.
  - Cycle t rotates lane r iff its rotation amount n(r) > t.
  - n(r)=r when INVERSE=0; n(r)=(4-r)%4 when INVERSE=1.
  - in_ready=0, out_valid=0. Ignores in_valid/out_ready.
- DRAIN:
  - out_valid=1, out_byte = tap of lane (cnt%4), out_last = (cnt==15).
  - On out_valid&out_ready: rotate lane (cnt%4), cnt increments.
  - Without out_ready: out_byte/out_last hold stable, no lane changes.
  - After the 16th accept: go to LOAD, cnt<=0.
  - Result: output beat 4c+r equals input[r][(c+n(r))%4].
- Latency: first out_valid is in the 4th cycle after the cycle of the 16th input accept (3 ROTATE cycles). Throughput is one block per 16+3+16 cycles minimum. LOAD and DRAIN do not overlap.
- in_ready, out_valid and out_last are decoded from state and cnt only. No combinational path from in_valid or out_ready to any output.
- busy = state is ROTATE or DRAIN.
- Reset (rst sampled high at clk edge) has priority over all events:
  - state=LOAD, cnt=0, ROTATE timer=0, all lane bytes=8'h00.
  - After reset: out_valid=0, out_last=0, out_byte=8'h00, busy=0.
  - in_ready is forced 0 while rst is high and is 1 in the first cycle after release.
  - A mid-block reset discards the partial block with no output.
- in_valid outside LOAD is ignored; no byte is accepted.
- A partial block (fewer than 16 bytes) is held indefinitely in LOAD; there is no timeout.

Test Plan:
- INVERSE=0; feed bytes 00..0F with out_ready=1 -> out stream 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B; out_last only on 0B; first out_valid exactly 4 cycles after the cycle that accepts 0F.
- INVERSE=1; same input -> 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03.
- Backpressure: toggle out_ready randomly during DRAIN -> same 16-byte sequence as the first scenario; out_byte stable while out_valid&!out_ready; in_ready=0 and busy=1 throughout ROTATE and DRAIN.
- Input gaps: in_valid deasserted for random cycles during LOAD -> identical output; in_valid held high during ROTATE/DRAIN accepts nothing; the next block starts cleanly after out_last and yields the correct sequence for input 10..1F.
- Reset mid-operation: assert rst after 7 input bytes, and separately after 5 output bytes -> out_valid=0, out_byte=00, busy=0 the next cycle; a fresh 00..0F block afterwards produces exactly the first scenario's sequence.
- Reset while in ROTATE -> returns to LOAD with in_ready=1 in the cycle after rst falls; no output beat is emitted.

Source files
------------

// File: rtl/aes_shiftrows_sched.sv
// aes_shiftrows_sched: byte-serial ShiftRows/InvShiftRows scheduler.
// A 16-byte AES state arrives column-major and is written into four 4-byte row lanes.
// Each lane is rotated by its row offset, and the result is drained column-major.
// Lane r's tap (s[3]) always presents the next column to emit for that row.
module aes_shiftrows_sched #(
    parameter int INVERSE = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_ROTATE = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0] state;
    logic [3:0] cnt;
    logic [1:0] rtimer;
    logic [1:0] sel;
    logic       in_fire;
    logic       out_fire;
    logic [7:0] tap [4];

    assign sel       = cnt[1:0];
    assign in_ready  = (state == ST_LOAD) && !rst;
    assign out_valid = (state == ST_DRAIN);
    assign out_last  = (state == ST_DRAIN) && (cnt == 4'd15);
    assign busy      = (state == ST_ROTATE) || (state == ST_DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_byte  = out_valid ? tap[sel] : 8'h00;

    for (genvar r = 0; r < 4; r++) begin : g_lane
        // Rotation amount for this row: r for ShiftRows, (4-r)%4 for InvShiftRows.
        localparam logic [2:0] NROT = (INVERSE != 0) ? 3'((4 - r) % 4) : 3'(r);

        logic [3:0][7:0] s;
        logic            ld;
        logic            rot;

        assign ld     = in_fire && (sel == 2'(r));
        assign rot    = ((state == ST_ROTATE) && ({1'b0, rtimer} < NROT))
                      || (out_fire && (sel == 2'(r)));
        assign tap[r] = s[3];

        // Lane storage: shift in a new byte while loading, recirculate while rotating/draining.
        always_ff @(posedge clk) begin
            if (rst) begin
                s <= '0;
            end else if (ld || rot) begin
                s[0] <= ld ? in_byte : s[3];
                s[1] <= s[0];
                s[2] <= s[1];
                s[3] <= s[2];
            end
        end
    end

    // Sequencer: LOAD 16 beats, ROTATE 3 cycles, DRAIN 16 beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_LOAD;
            cnt    <= '0;
            rtimer <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        if (cnt == 4'd15) begin
                            cnt   <= '0;
                            state <= ST_ROTATE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                ST_ROTATE: begin
                    if (rtimer == 2'd2) begin
                        rtimer <= '0;
                        state  <= ST_DRAIN;
                    end else begin
                        rtimer <= rtimer + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (cnt == 4'd15) begin
                            cnt   <= '0;
                            state <= ST_LOAD;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state  <= ST_LOAD;
                    cnt    <= '0;
                    rtimer <= '0;
                end
            endcase
        end
    end

endmodule
